// File: rtl/trap_sequencer.sv
// Trap/interrupt/mret sequencer in front of the machine-mode CSR file.
// Arbitrates one event in IDLE, then walks stall -> drain -> issue -> wait redirect -> release.
module trap_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   exc_valid,
    input  logic [19:0]  exc_cause,
    input  logic [127:0] exc_pc,
    input  logic         irq_pending,
    input  logic         mret_req,
    input  logic [31:0]  retire_pc,
    input  logic         csr_redirect,
    output logic         stall,
    output logic         flush,
    output logic         trap_valid,
    output logic         irq_take,
    output logic         mret_take,
    output logic [31:0]  trap_cause,
    output logic [31:0]  trap_pc,
    output logic         seq_err,
    output logic [15:0]  trap_count,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ISSUE,
        S_WAIT_ACK,
        S_RECOVER
    } state_t;

    typedef enum logic [1:0] {
        K_EXC,
        K_IRQ,
        K_MRET
    } kind_t;

    localparam logic [3:0] DRAIN_M1   = 4'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
    localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

    state_t       state_q, state_d;
    kind_t        kind_q, kind_d;
    logic [3:0]   drain_cnt_q, drain_cnt_d;
    logic [7:0]   tmo_cnt_q, tmo_cnt_d;
    logic [15:0]  trap_count_q, trap_count_d;
    logic [31:0]  trap_cause_q, trap_cause_d;
    logic [31:0]  trap_pc_q, trap_pc_d;
    logic         stall_q, stall_d;
    logic         busy_q, busy_d;
    logic         flush_q, flush_d;
    logic         trap_valid_q, trap_valid_d;
    logic         irq_take_q, irq_take_d;
    logic         mret_take_q, mret_take_d;
    logic         seq_err_q, seq_err_d;

    logic [4:0]   sel_cause;
    logic [31:0]  sel_pc;
    logic         capture;

    // Oldest stage wins: later loop iterations override earlier ones.
    always_comb begin
        sel_cause = 5'd0;
        sel_pc    = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (exc_valid[i]) begin
                sel_cause = exc_cause[5*i +: 5];
                sel_pc    = exc_pc[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        drain_cnt_d  = drain_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        trap_count_d = trap_count_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;
        seq_err_d    = 1'b0;
        capture      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|exc_valid) begin
                    capture      = 1'b1;
                    kind_d       = K_EXC;
                    trap_cause_d = {27'd0, sel_cause};
                    trap_pc_d    = sel_pc;
                end else if (irq_pending) begin
                    capture      = 1'b1;
                    kind_d       = K_IRQ;
                    trap_cause_d = IRQ_CAUSE;
                    trap_pc_d    = retire_pc;
                end else if (mret_req) begin
                    capture      = 1'b1;
                    kind_d       = K_MRET;
                    trap_pc_d    = retire_pc;
                end
                if (capture) begin
                    state_d     = (DRAIN_CYCLES == 0) ? S_ISSUE : S_DRAIN;
                    drain_cnt_d = DRAIN_M1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == 4'd0) begin
                    state_d = S_ISSUE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = 8'd0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (csr_redirect) begin
                    state_d = S_RECOVER;
                end else if (tmo_cnt_q == TIMEOUT_M1) begin
                    seq_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count on entry to ISSUE so the value seen with the strobe includes this event.
        if (state_d == S_ISSUE && state_q != S_ISSUE && trap_count_q != 16'hFFFF) begin
            trap_count_d = trap_count_q + 16'd1;
        end

        stall_d      = (state_d != S_IDLE);
        busy_d       = (state_d != S_IDLE);
        flush_d      = (state_d == S_ISSUE);
        trap_valid_d = flush_d && (kind_d == K_EXC);
        irq_take_d   = flush_d && (kind_d == K_IRQ);
        mret_take_d  = flush_d && (kind_d == K_MRET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            kind_q       <= K_EXC;
            drain_cnt_q  <= 4'd0;
            tmo_cnt_q    <= 8'd0;
            trap_count_q <= 16'd0;
            trap_cause_q <= 32'd0;
            trap_pc_q    <= 32'd0;
            stall_q      <= 1'b0;
            busy_q       <= 1'b0;
            flush_q      <= 1'b0;
            trap_valid_q <= 1'b0;
            irq_take_q   <= 1'b0;
            mret_take_q  <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            drain_cnt_q  <= drain_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            trap_count_q <= trap_count_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
            stall_q      <= stall_d;
            busy_q       <= busy_d;
            flush_q      <= flush_d;
            trap_valid_q <= trap_valid_d;
            irq_take_q   <= irq_take_d;
            mret_take_q  <= mret_take_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign stall      = stall_q;
    assign busy       = busy_q;
    assign flush      = flush_q;
    assign trap_valid = trap_valid_q;
    assign irq_take   = irq_take_q;
    assign mret_take  = mret_take_q;
    assign trap_cause = trap_cause_q;
    assign trap_pc    = trap_pc_q;
    assign seq_err    = seq_err_q;
    assign trap_count = trap_count_q;

endmodule
